// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD adder: FSM encoding and default operand width.
package bcd_pkg;

    localparam int unsigned NdigDefault = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/BCD_1Digit.sv
// Single-digit decimal adder: binary add, then +6 correction when the raw sum exceeds 9.
module BCD_1Digit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);

    logic [4:0] raw;

    assign raw    = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};
    assign cout_o = (raw > 5'd9);
    // Non-BCD inputs are corrected the same way; the wrap past 15 is intentional.
    assign sum_o  = cout_o ? (raw[3:0] + 4'd6) : raw[3:0];

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one digit per clock, LSD first, through a single BCD_1Digit.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int unsigned NDIG = NdigDefault
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4*NDIG-1:0] a,
    input  logic [4*NDIG-1:0] b,
    input  logic              cin,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] sum,
    output logic              cout,
    output logic              err
);

    localparam int unsigned W  = 4 * NDIG;
    localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          err_q, err_d;

    logic [3:0]    a_dig, b_dig, dig_sum;
    logic          dig_cout;
    logic          last_dig;
    logic          bad_in;

    assign a_dig    = a_q[{idx_q, 2'b00} +: 4];
    assign b_dig    = b_q[{idx_q, 2'b00} +: 4];
    assign last_dig = (idx_q == IW'(NDIG - 1));

    BCD_1Digit u_digit (
        .a_i    (a_dig),
        .b_i    (b_dig),
        .cin_i  (carry_q),
        .sum_o  (dig_sum),
        .cout_o (dig_cout)
    );

    always_comb begin
        bad_in = 1'b0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
                bad_in = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    idx_d   = '0;
                    carry_d = cin;
                    a_d     = a;
                    b_d     = b;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    err_d   = bad_in;
                end else if (state_q == StDone) begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                sum_d[{idx_q, 2'b00} +: 4] = dig_sum;
                carry_d = dig_cout;
                if (last_dig) begin
                    state_d = StDone;
                    cout_d  = dig_cout;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Randomised and directed checks of bcd_serial_adder (NDIG=4) against a decimal reference model.
module tb_bcd_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        busy, done, cout, err;
    logic [15:0] sum;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    bcd_serial_adder #(.NDIG(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit has_bad(input logic [15:0] x, input logic [15:0] y);
        for (int i = 0; i < 4; i++) if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    // Valid operands: ordinary decimal arithmetic. Otherwise: per-digit add-and-correct rule.
    function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                            input logic c);
        logic [15:0] s = '0;
        int          carry = c;
        if (!has_bad(x, y)) begin
            int vx = 0, vy = 0, v, pw = 1;
            for (int i = 0; i < 4; i++) begin
                vx += int'(x[4*i +: 4]) * pw;
                vy += int'(y[4*i +: 4]) * pw;
                pw *= 10;
            end
            v = vx + vy + c;
            carry = (v >= 10000) ? 1 : 0;
            v = v % 10000;
            for (int i = 0; i < 4; i++) begin
                s[4*i +: 4] = 4'(v % 10);
                v = v / 10;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                int t = int'(x[4*i +: 4]) + int'(y[4*i +: 4]) + carry;
                if (t > 9) begin
                    s[4*i +: 4] = 4'((t + 6) % 16);
                    carry = 1;
                end else begin
                    s[4*i +: 4] = 4'(t);
                    carry = 0;
                end
            end
        end
        return {carry[0], s};
    endfunction

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                          input bit repulse);
        logic [16:0] exp;
        int          n;
        int          d0;
        exp = ref_add(ta, tb_v, tc);
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        d0 = done_cnt;
        check_eq("busy_after_capture", busy, 1);
        check_eq("cout_in_run", cout, 0);
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            if (repulse && n == 1) begin
                @(negedge clk);
                a = 16'h1111; b = 16'h2222; cin = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check_eq("latency", n, 4);
        check_eq("sum", sum, exp[15:0]);
        check_eq("cout", cout, exp[16]);
        check_eq("err", err, has_bad(ta, tb_v));
        @(posedge clk);
        #1;
        check_eq("done_one_cycle", done, 0);
        check_eq("idle_not_busy", busy, 0);
        check_eq("sum_held", sum, exp[15:0]);
        check_eq("err_held", err, has_bad(ta, tb_v));
        @(negedge clk);
        check_eq("done_pulses", done_cnt - d0, 1);
    endtask

    initial begin
        int          e;
        int          first_done, second_done;
        logic [15:0] ra, rb;

        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_sum", sum, 0);
        check_eq("rst_cout", cout, 0);
        check_eq("rst_err", err, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op(16'h1234, 16'h5678, 1'b0, 1'b0);
        run_op(16'h9999, 16'h0001, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0);
        run_op(16'h00A0, 16'h0000, 1'b0, 1'b0);
        run_op(16'h0042, 16'h0017, 1'b0, 1'b0);
        run_op(16'h2468, 16'h1357, 1'b1, 1'b1);

        // Asynchronous reset in the second RUN cycle.
        @(negedge clk);
        a = 16'h12A4; b = 16'h5678; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("err_before_rst", err, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_sum", sum, 0);
        check_eq("midrst_cout", cout, 0);
        check_eq("midrst_err", err, 0);
        e = done_cnt;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_eq("no_done_after_rst", done_cnt - e, 0);
        run_op(16'h0500, 16'h0500, 1'b0, 1'b0);

        // Back-to-back with start held high across two operations.
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        a = 16'h4999; b = 16'h5000;
        e = 0; first_done = -1; second_done = -1;
        while (e < 20 && second_done < 0) begin
            @(posedge clk);
            #1;
            e++;
            if (e == 5) start = 1'b0;
            if (done) begin
                if (first_done < 0) begin
                    first_done = e;
                    check_eq("b2b_sum1", sum, 16'h0002);
                    check_eq("b2b_cout1", cout, 0);
                end else begin
                    second_done = e;
                    check_eq("b2b_sum2", sum, 16'h9999);
                    check_eq("b2b_cout2", cout, 0);
                end
            end
        end
        check_eq("b2b_first_latency", first_done, 4);
        check_eq("b2b_spacing", second_done - first_done, 5);
        start = 1'b0;
        repeat (2) @(posedge clk);

        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < 4; i++) begin
                ra[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                           : 4'($urandom_range(0, 9));
                rb[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                           : 4'($urandom_range(0, 9));
            end
            run_op(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
